// File: rtl/arith_pkg.sv
// Shared encodings for the sequential arithmetic unit: operation select codes
// and the controller state enumeration.
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_arith_muldiv_core.sv
// Iterative datapath: LSB-first shift-add multiply or restoring divide, one
// step per strobe. hi_nxt/lo_nxt expose the register values after the pending step.
module seq_arith_muldiv_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    // hi: product high half / partial remainder; lo: multiplier / dividend-quotient
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[WIDTH-1]};
        trial   = shifted - {1'b0, opnd};
        fits    = (shifted >= {1'b0, opnd});
        if (div_mode) begin
            hi_nxt = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], fits};
        end else begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    // Multiplication commutes, so both modes load a into lo and b into opnd.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
        end else if (load) begin
            hi   <= '0;
            lo   <= a;
            opnd <= b;
        end else if (step) begin
            hi   <= hi_nxt;
            lo   <= lo_nxt;
        end
    end

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential arithmetic unit: single-cycle add/subtract, WIDTH-step multiply
// and divide, with result/flag registers that change only when done rises.
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e          state, state_d;
    op_e             op_in, op_q;
    logic [CW-1:0]   cnt;
    logic            accept, long_op, last_step;
    logic [WIDTH:0]  sum, diff;
    logic [WIDTH-1:0] fast_res, fast_rem;
    logic            fast_ovf, fast_dbz;
    logic [WIDTH-1:0] core_hi, core_lo;

    assign op_in     = op_e'(op_sel);
    assign busy      = (state == CALC);
    assign done      = (state == DONE);
    assign accept    = start && (state != CALC);
    assign long_op   = (op_in == OP_MUL) || ((op_in == OP_DIV) && (b != '0));
    assign last_step = (state == CALC) && (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_d = long_op ? CALC : DONE;
                else        state_d = IDLE;
            end
            CALC:    if (last_step) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Results for operations that complete without iterating.
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        fast_res = '0;
        fast_rem = '0;
        fast_ovf = 1'b0;
        fast_dbz = 1'b0;
        case (op_in)
            OP_ADD: begin
                fast_res = sum[WIDTH-1:0];
                fast_ovf = sum[WIDTH];
            end
            OP_SUB: begin
                fast_res = diff[WIDTH-1:0];
                fast_ovf = diff[WIDTH];
            end
            default: begin
                fast_res = '1;
                fast_rem = a;
                fast_ovf = 1'b1;
                fast_dbz = 1'b1;
            end
        endcase
    end

    seq_arith_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && long_op),
        .step     (state == CALC),
        .div_mode (op_q == OP_DIV),
        .a        (a),
        .b        (b),
        .hi_nxt   (core_hi),
        .lo_nxt   (core_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= OP_ADD;
            cnt         <= '0;
            result      <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                op_q <= op_in;
                cnt  <= '0;
                if (!long_op) begin
                    result      <= fast_res;
                    remainder   <= fast_rem;
                    overflow    <= fast_ovf;
                    div_by_zero <= fast_dbz;
                end
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                // Capture the final step's values so outputs change with done.
                if (last_step) begin
                    result      <= core_lo;
                    remainder   <= (op_q == OP_DIV) ? core_hi : '0;
                    overflow    <= (op_q == OP_MUL) ? (core_hi != '0) : 1'b0;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/seq_arith_unit.md
SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-004 start  input  1  request pulse; accepted only when busy=0.
REQ-005 op_sel  input  2  operation: 00 add, 01 subtract, 10 multiply, 11 divide.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 busy  output  1  operation in progress; high from the cycle after acceptance until the cycle before done.
REQ-009 done  output  1  single-cycle completion pulse; result, remainder and flags are valid from that cycle onward.
REQ-010 result  output  WIDTH  sum, difference, low product half, or quotient.
REQ-011 remainder  output  WIDTH  divide remainder; 0 for all other ops.
REQ-012 overflow  output  1  result not representable in WIDTH bits, or divide by zero.
REQ-013 div_by_zero  output  1  divide issued with b=0.

Function
REQ-014 Acceptance: start=1 and busy=0 at a rising edge latches a, b and op_sel; later input changes have no effect on the operation.
REQ-015 FSM states: IDLE, CALC, DONE. IDLE->CALC on an accepted multiply/divide with b!=0. IDLE->DONE on an accepted add/subtract or divide with b=0. CALC->DONE when the iteration count reaches WIDTH. DONE->IDLE unconditionally, or DONE->CALC/DONE directly on a start accepted in DONE.
REQ-016 busy=1 only in CALC; done=1 only in DONE; start is accepted in IDLE and DONE (back-to-back) and ignored in CALC.
REQ-017 Add/subtract latency: done high in the cycle after acceptance (1 cycle).
REQ-018 Multiply/divide latency: exactly WIDTH+1 cycles from acceptance to done, with one iteration per CALC cycle.
REQ-019 Add: result = (a+b) mod 2^WIDTH; overflow = carry-out.
REQ-020 Subtract: result = (a-b) mod 2^WIDTH; overflow = borrow (a<b).
REQ-021 Multiply: iterative shift-add over a 2*WIDTH-bit product; result = low half; overflow = 1 when the high half is non-zero.
REQ-022 Divide: restoring divide, one quotient bit per cycle; result = quotient, remainder = a mod b, overflow=0.
REQ-023 Divide with b=0: no iteration; result = all ones, remainder = a, overflow=1, div_by_zero=1, latency 1.
REQ-024 div_by_zero=0 for every other case.
REQ-025 result, remainder, overflow and div_by_zero update only in the cycle done rises, and hold until the next done.

Reset
REQ-026 rst_n=0 at a rising edge forces state IDLE and busy=0, done=0, result=0, remainder=0, overflow=0, div_by_zero=0, and clears the iteration counter and working registers.
REQ-027 Reset mid-operation aborts that operation: no done pulse follows, and the first start after reset release is accepted normally.
REQ-028 start asserted in the same cycle as rst_n=0 is ignored.

Structure
REQ-029 A shared package arith_pkg holds the op_sel encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the FSM state enumeration.
REQ-030 The shift-add/restoring datapath is a single sub-module seq_arith_muldiv_core (inputs: operands, mode and a step strobe; outputs: product/quotient/remainder). The FSM, counter and add/subtract logic stay in seq_arith_unit.

Verification (WIDTH=4 unless stated)
REQ-031 add a=5, b=3 -> done at +1 cycle, result=8, overflow=0; add a=15, b=1 -> result=0, overflow=1.
REQ-032 sub a=8, b=3 -> result=5, overflow=0; sub a=3, b=4 -> result=15, overflow=1, both at +1 cycle.
REQ-033 mul a=2, b=3 -> done at +5 cycles, result=6, overflow=0; mul a=4, b=4 -> result=0, overflow=1; busy high exactly 4 cycles.
REQ-034 div a=13, b=3 -> done at +5 cycles, result=4, remainder=1; div a=8, b=0 -> done at +1 cycle, result=15, remainder=8, overflow=1, div_by_zero=1.
REQ-035 start pulsed during CALC of mul 4*4 with a=1, b=1 -> ignored, and the original mul result is delivered; a start accepted in the DONE cycle runs back-to-back.
REQ-036 rst_n low at cycle 2 of mul a=7, b=7 (WIDTH=8) -> all outputs 0 next cycle, no done pulse; a following add 1+1 returns 2 at +1 cycle.
